// File: rtl/result_ascii_serializer_pkg.sv
// Shared constants and state encoding for the ALU-result-to-UART ASCII formatter.
package uart_alu_defs;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam int unsigned MAX_CHARS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASC_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/result_ascii_serializer_bin2bcd_seq.sv
// Iterative double-dabble: 8-bit binary to three BCD digits, one shift per cycle.
// o_done rises exactly 8 cycles after i_start and stays high for one cycle.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic [11:0] o_bcd,
    output logic        o_done
);

    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_active;
    logic [11:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned d = 0; d < 3; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_bin    <= i_bin;
            r_bcd    <= '0;
            r_cnt    <= 4'd8;
            r_active <= 1'b1;
        end else if (r_cnt != 4'd0) begin
            {r_bcd, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
            r_cnt          <= r_cnt - 4'd1;
        end else begin
            r_active <= 1'b0;
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = r_active && (r_cnt == 4'd0);

endmodule

// File: rtl/result_ascii_serializer.sv
// Formats one 8-bit ALU result as decimal ASCII (optional sign, optional CR LF)
// and streams it byte by byte over a valid/ready pair towards UART_TX.
module result_ascii_serializer
    import uart_alu_defs::*;
#(
    parameter bit SIGNED_MODE = 1'b0,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    state_t r_state, w_next;

    logic                         w_accept;
    logic                         w_is_neg;
    logic [7:0]                   w_mag;
    logic [11:0]                  w_bcd;
    logic                         w_done;
    logic                         w_last;
    logic                         r_neg;
    logic [MAX_CHARS-1:0][7:0]    r_list, w_list;
    logic [2:0]                   r_idx, r_len, w_len;

    assign w_accept = valid_in && (r_state == IDLE);
    assign w_is_neg = SIGNED_MODE && data_i[7];
    // 8'h80 negates to itself, which read as unsigned is the wanted 128
    assign w_mag    = w_is_neg ? (8'd0 - data_i) : data_i;
    assign w_last   = (r_idx == r_len - 3'd1);

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept),
        .i_bin   (w_mag),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    // Packs the string front-to-back; w_len doubles as the write pointer.
    always_comb begin
        w_list = '0;
        w_len  = '0;
        if (r_neg) begin
            w_list[w_len] = ASC_MINUS;
            w_len         = w_len + 3'd1;
        end
        if (w_bcd[11:8] != 4'd0) begin
            w_list[w_len] = digit_char(w_bcd[11:8]);
            w_len         = w_len + 3'd1;
        end
        if (w_bcd[11:4] != 8'd0) begin
            w_list[w_len] = digit_char(w_bcd[7:4]);
            w_len         = w_len + 3'd1;
        end
        w_list[w_len] = digit_char(w_bcd[3:0]);
        w_len         = w_len + 3'd1;
        if (APPEND_CRLF) begin
            w_list[w_len] = ASC_CR;
            w_len         = w_len + 3'd1;
            w_list[w_len] = ASC_LF;
            w_len         = w_len + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ready_in  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) w_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (w_done) w_next = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg  <= 1'b0;
            r_list <= '0;
            r_len  <= '0;
            r_idx  <= '0;
        end else begin
            if (w_accept) begin
                r_neg <= w_is_neg;
            end
            if ((r_state == CONV) && w_done) begin
                r_list <= w_list;
                r_len  <= w_len;
                r_idx  <= '0;
            end
            if ((r_state == EMIT) && out_ready) begin
                r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    assign out_data = r_list[r_idx];

endmodule
